cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter LINE_W, default 256, cache-line data width in bits.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 i_read  input  1  instruction-cache line-fill request.
REQ-006 i_address  input  ADDR_W  instruction-cache line address.
REQ-007 i_rdata  output  LINE_W  fill data returned to instruction cache.
REQ-008 i_resp  output  1  one-cycle completion pulse to instruction cache.
REQ-009 d_read / d_write  input  1 each  data-cache fill / writeback request.
REQ-010 d_address  input  ADDR_W  data-cache line address.
REQ-011 d_wdata  input  LINE_W  writeback line.
REQ-012 d_rdata  output  LINE_W  fill data returned to data cache.
REQ-013 d_resp  output  1  one-cycle completion pulse to data cache.
REQ-014 mem_read / mem_write  output  1 each  request to the shared lower-level memory port.
REQ-015 mem_address  output  ADDR_W  and mem_wdata  output  LINE_W  latched request payload.
REQ-016 mem_rdata  input  LINE_W  and mem_resp  input  1  memory completion.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, SERVE_I, SERVE_D.
REQ-018 In IDLE with exactly one requester active, the FSM SHALL enter that requester's SERVE state on the next edge.
REQ-019 In IDLE with both requesters active, the grant SHALL go to the requester not recorded in last_grant (round-robin).
REQ-020 On entering SERVE_x, the arbiter SHALL latch the address, operation and wdata, and drive mem_* only from the latched copy.
REQ-021 mem_read/mem_write SHALL be asserted only in SERVE states and held until mem_resp, even if the requester drops its request.
REQ-022 Arbitration latency SHALL be one cycle: a request seen in IDLE at cycle N gives mem_read/mem_write high at cycle N+1.
REQ-023 On mem_resp in SERVE_x, x_resp SHALL be high in that same cycle, x_rdata SHALL equal mem_rdata, and the FSM SHALL return to IDLE.
REQ-024 The non-granted requester's resp SHALL be 0 at all times; its rdata SHALL be don't-care.
REQ-025 last_grant SHALL update on the cycle the grant is taken.
REQ-026 With d_read and d_write both high, the arbiter SHALL latch a write (d_write wins).
REQ-027 IDLE SHALL last at least one cycle between transactions, and requests are not sampled in the mem_resp cycle.
REQ-028 A mem_resp arriving in IDLE SHALL be ignored and produce no resp pulse.

Reset
REQ-029 While rst is high: state = IDLE; mem_read, mem_write, i_resp and d_resp = 0; latched address/wdata = 0; last_grant = D, so the first tie goes to I.
REQ-030 Reset asserted mid-transaction SHALL abandon the transfer with no resp pulse; the requester re-requests afterwards.

Structure
REQ-031 The arb_state_t enum (IDLE, SERVE_I, SERVE_D) and the grant_t enum (GRANT_I, GRANT_D) SHALL live in a shared package imported alongside rv32i_types.
REQ-032 Line width SHALL come only from LINE_W; no hard-coded 256 in the body.
REQ-033 The block is a single module with no sub-modules; payload latching is local registers.

Verification
REQ-034 i_read=1, i_address=0x0000_0060 at cycle 0; mem_resp at cycle 4 with mem_rdata=all-0xA5 -> mem_read high for cycles 1-4, mem_address=0x60, i_resp=1 only at cycle 4, i_rdata=all-0xA5.
REQ-035 After reset, i_read and d_read both rise at cycle 0 -> I served first; D granted at the first IDLE after i_resp; next tie goes to I.
REQ-036 d_write=1, d_address=0x1000, d_wdata=pattern P; requester deasserts at cycle 2; mem_resp at cycle 5 -> mem_write held for cycles 1-5, mem_wdata=P, d_resp at cycle 5.
REQ-037 d_read and d_write both high -> mem_write=1 and mem_read=0 throughout.
REQ-038 rst pulsed at cycle 3 of a SERVE_D transfer -> cycle 4 is IDLE with all outputs 0; a later mem_resp gives no d_resp.
REQ-039 Continuous i_read and d_read for 10 transactions with 2-cycle memory -> grants strictly alternate and no resp ever lands on the wrong port.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D cache-to-memory arbiter.
package cache_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // A lone requester always wins; on a tie the side not granted last time wins.
    function automatic grant_t pick_grant(input logic i_req, input logic d_req,
                                          input grant_t last);
        if (i_req && d_req) begin
            pick_grant = (last == GRANT_D) ? GRANT_I : GRANT_D;
        end else if (i_req) begin
            pick_grant = GRANT_I;
        end else begin
            pick_grant = GRANT_D;
        end
    endfunction

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between an instruction
// cache (fills only) and a data cache (fills and writebacks).
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t        state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;      // latched operation: 1 = writeback, 0 = fill
    logic              d_req;
    logic              busy;
    grant_t            pick;

    // Next-state, payload capture and memory/response outputs.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_d         = wr_q;
        d_req        = d_read | d_write;
        pick         = pick_grant(i_read, d_req, last_grant_q);
        busy         = !rst && (state_q != IDLE);
        mem_read     = busy && !wr_q;
        mem_write    = busy && wr_q;
        mem_address  = addr_q;
        mem_wdata    = wdata_q;
        i_resp       = !rst && (state_q == SERVE_I) && mem_resp;
        d_resp       = !rst && (state_q == SERVE_D) && mem_resp;

        case (state_q)
            IDLE: begin
                if (i_read || d_req) begin
                    last_grant_d = pick;
                    if (pick == GRANT_I) begin
                        state_d = SERVE_I;
                        addr_d  = i_address;
                        wr_d    = 1'b0;
                        wdata_d = '0;
                    end else begin
                        // A simultaneous read+write from the data cache is a writeback.
                        state_d = SERVE_D;
                        addr_d  = d_address;
                        wr_d    = d_write;
                        wdata_d = d_wdata;
                    end
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Fill data goes to both caches; only the granted side sees a resp pulse.
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    // State and latched-payload registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_D;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_q         <= wr_d;
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model every cycle.
module tb_cache_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;

    int errors = 0;
    int checks = 0;

    cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Transaction-level model: who owns the memory port (0 none, 1 I, 2 D),
    // what was captured when the grant was taken, and who won last.
    int            m_owner = 0;
    int            m_last  = 2;
    logic [AW-1:0] m_addr  = '0;
    logic [LW-1:0] m_wdata = '0;
    bit            m_wr    = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_mem_read", mem_read, 1'b0);
            check("rst_mem_write", mem_write, 1'b0);
            check("rst_i_resp", i_resp, 1'b0);
            check("rst_d_resp", d_resp, 1'b0);
            m_owner = 0;
            m_last  = 2;
            m_addr  = '0;
            m_wdata = '0;
            m_wr    = 1'b0;
        end else begin
            check("mdl_mem_read", mem_read, (m_owner != 0) && !m_wr);
            check("mdl_mem_write", mem_write, (m_owner != 0) && m_wr);
            check("mdl_i_resp", i_resp, (m_owner == 1) && mem_resp);
            check("mdl_d_resp", d_resp, (m_owner == 2) && mem_resp);
            if (m_owner != 0) begin
                check("mdl_mem_address", mem_address, m_addr);
                if (m_wr) check("mdl_mem_wdata", mem_wdata, m_wdata);
            end
            if (m_owner == 1 && mem_resp) check("mdl_i_rdata", i_rdata, mem_rdata);
            if (m_owner == 2 && mem_resp) check("mdl_d_rdata", d_rdata, mem_rdata);

            if (m_owner != 0) begin
                if (mem_resp) m_owner = 0;
            end else begin
                int want;
                bit ireq, dreq;
                ireq = i_read;
                dreq = d_read || d_write;
                if (ireq && dreq)  want = (m_last == 1) ? 2 : 1;
                else if (ireq)     want = 1;
                else if (dreq)     want = 2;
                else               want = 0;
                if (want != 0) begin
                    m_owner = want;
                    m_last  = want;
                    if (want == 1) begin
                        m_addr  = i_address;
                        m_wr    = 1'b0;
                        m_wdata = '0;
                    end else begin
                        m_addr  = d_address;
                        m_wr    = d_write;
                        m_wdata = d_wdata;
                    end
                end
            end
        end
    end

    initial begin
        logic [LW-1:0] pat;
        logic [LW-1:0] a5;
        int            txn;
        int            prev;
        int            busy_cnt;
        bit            i_pend, d_pend, active;
        int            d_op;

        rst = 1'b1;
        i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
        mem_rdata = '0; mem_resp = 1'b0;
        a5 = {32{8'hA5}};
        tick();
        tick();
        #1;
        check("reset_mem_read", mem_read, 1'b0);
        check("reset_mem_address", mem_address, '0);
        tick();

        // Tie straight after reset: I first, then D, then I again.
        do_reset();
        i_read = 1'b1; i_address = 32'h100;
        d_read = 1'b1; d_address = 32'h200;
        tick();
        #1;
        check("tie_first_is_i", mem_address, 32'h100);
        check("tie_first_read", mem_read, 1'b1);
        tick();
        mem_resp = 1'b1; mem_rdata = rand_line();
        #1;
        check("tie_i_resp", i_resp, 1'b1);
        check("tie_d_no_resp", d_resp, 1'b0);
        tick();
        mem_resp = 1'b0; i_read = 1'b0;
        #1;
        check("tie_idle_gap", mem_read, 1'b0);
        tick();
        i_read = 1'b1;
        #1;
        check("tie_second_is_d", mem_address, 32'h200);
        mem_resp = 1'b1;
        #1;
        check("tie_d_resp", d_resp, 1'b1);
        tick();
        mem_resp = 1'b0;
        tick();
        #1;
        check("tie_third_is_i", mem_address, 32'h100);
        mem_resp = 1'b1;
        #1;
        check("tie_third_i_resp", i_resp, 1'b1);
        tick();
        mem_resp = 1'b0; i_read = 1'b0; d_read = 1'b0;
        tick();

        // Instruction fill with a four-cycle memory.
        i_read = 1'b1; i_address = 32'h0000_0060;
        tick();
        i_read = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin mem_resp = 1'b1; mem_rdata = a5; end
            #1;
            check("ifill_mem_read", mem_read, 1'b1);
            check("ifill_mem_address", mem_address, 32'h60);
            check("ifill_i_resp", i_resp, c == 4);
            if (c == 4) check("ifill_i_rdata", i_rdata, a5);
            tick();
        end
        mem_resp = 1'b0;
        #1;
        check("ifill_done", mem_read, 1'b0);
        tick();

        // Writeback held after the requester drops; payload comes from the latch.
        pat = rand_line();
        d_write = 1'b1; d_address = 32'h1000; d_wdata = pat;
        tick();
        for (int c = 1; c <= 5; c++) begin
            if (c == 2) begin d_write = 1'b0; d_wdata = ~pat; d_address = 32'hdead_0000; end
            if (c == 5) mem_resp = 1'b1;
            #1;
            check("wb_mem_write", mem_write, 1'b1);
            check("wb_mem_wdata", mem_wdata, pat);
            check("wb_mem_address", mem_address, 32'h1000);
            check("wb_d_resp", d_resp, c == 5);
            tick();
        end
        mem_resp = 1'b0;
        #1;
        check("wb_done", mem_write, 1'b0);
        tick();

        // Read and write together: writeback wins.
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h2000; d_wdata = rand_line();
        tick();
        d_read = 1'b0; d_write = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            if (c == 2) mem_resp = 1'b1;
            #1;
            check("rw_mem_write", mem_write, 1'b1);
            check("rw_mem_read", mem_read, 1'b0);
            tick();
        end
        mem_resp = 1'b0;
        tick();

        // Reset in the middle of a data fill abandons it.
        d_read = 1'b1; d_address = 32'h3000;
        tick();
        d_read = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("abort_rst_mem_read", mem_read, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check("abort_mem_read", mem_read, 1'b0);
        check("abort_mem_write", mem_write, 1'b0);
        check("abort_i_resp", i_resp, 1'b0);
        check("abort_d_resp", d_resp, 1'b0);
        check("abort_mem_address", mem_address, '0);
        tick();
        mem_resp = 1'b1;
        #1;
        check("abort_late_resp", d_resp, 1'b0);
        tick();
        mem_resp = 1'b0;
        tick();

        // Continuous contention with a two-cycle memory: grants alternate.
        i_read = 1'b1; i_address = 32'h40;
        d_read = 1'b1; d_address = 32'h80;
        txn = 0; prev = 0; busy_cnt = 0;
        for (int c = 0; c < 100 && txn < 10; c++) begin
            if (mem_read || mem_write) busy_cnt++;
            else busy_cnt = 0;
            mem_resp = (busy_cnt == 2);
            mem_rdata = rand_line();
            #1;
            if (i_resp || d_resp) begin
                int port;
                check("alt_single_resp", i_resp && d_resp, 1'b0);
                port = i_resp ? 1 : 2;
                if (prev == 0) check("alt_first_is_i", port, 1);
                else           check("alt_switches", port == prev, 1'b0);
                prev = port;
                txn++;
            end
            tick();
        end
        check("alt_txn_count", txn, 10);
        i_read = 1'b0; d_read = 1'b0; mem_resp = 1'b0;
        tick();
        tick();

        // Randomized traffic, spurious responses and occasional resets.
        i_pend = 1'b0; d_pend = 1'b0; d_op = 0;
        for (int c = 0; c < 3000; c++) begin
            active = mem_read || mem_write;
            rst = ($urandom_range(0, 299) == 0);
            if (!i_pend && $urandom_range(0, 3) == 0) begin
                i_pend = 1'b1;
                i_address = $urandom & ~32'h1f;
            end
            if (!d_pend && $urandom_range(0, 3) == 0) begin
                d_pend = 1'b1;
                d_address = $urandom & ~32'h1f;
                d_op = $urandom_range(0, 2);
                d_wdata = rand_line();
            end
            i_read  = i_pend;
            d_read  = d_pend && (d_op != 1);
            d_write = d_pend && (d_op != 0);
            mem_resp  = active ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            mem_rdata = rand_line();
            #1;
            if (i_resp) i_pend = 1'b0;
            if (d_resp) d_pend = 1'b0;
            tick();
        end
        rst = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
